// File: rtl/tag_flush_sched.sv
// tag_flush_sched
//   Walks once over every downstream row buffer per pass. For each row it
//   picks one requesting column by round-robin, broadcasts that column's tag
//   (column index + 1; 0 means "no tag") with a one-hot flush strobe to the
//   row, then waits for the row to report a lock. If no lock arrives in time,
//   it raises a sticky error and moves on to the next row.
//
//   state | meaning
//   IDLE  | waiting for start
//   ARB   | pick a winner for row rp; hold while nothing is requested
//   FLUSH | one cycle: gnt / flush_tag / tag_out driven
//   WAIT  | waiting for row_lock[rp] or the lock timeout
//   DONE  | one-cycle done pulse, busy already low
//
// Ports
//   clk       : clock, rising edge
//   rstn      : asynchronous reset, active-low
//   start     : begin a pass (only honoured in IDLE)
//   req       : per-column request to publish its tag
//   row_lock  : per-row lock status from the row buffers
//   flush_tag : one-hot flush strobe to the row buffers
//   tag_out   : tag broadcast to all row buffers
//   gnt       : one-hot grant to the winning column
//   busy      : pass in progress
//   done      : one-cycle pulse at the end of a pass
//   err       : sticky lock-timeout flag, cleared by reset or accepted start
module tag_flush_sched #(
  parameter int NUM_COL = 4,
  parameter int NUM_ROW = 4,
  parameter int TIMEOUT = 15,
  localparam int TW = $clog2(NUM_COL) + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [NUM_COL-1:0] req,
  input  logic [NUM_ROW-1:0] row_lock,
  output logic [NUM_ROW-1:0] flush_tag,
  output logic [TW-1:0]      tag_out,
  output logic [NUM_COL-1:0] gnt,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam int RW = $clog2(NUM_ROW) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, ARB, FLUSH, WAIT, DONE} state_t;

  state_t        state;
  logic [RW-1:0] rp;
  logic [WW-1:0] wcnt;
  logic [CW-1:0] last_winner;
  logic [CW-1:0] cur_win;

  logic [CW-1:0]      win;
  logic               win_found;
  logic [NUM_COL-1:0] win_oh;
  logic [NUM_ROW-1:0] row_oh;
  logic               lock_cur;
  logic [WW-1:0]      wcnt_nxt;
  logic               last_row;

  // Round-robin search: first requesting column at offsets 1..NUM_COL
  // from last_winner, wrapping modulo NUM_COL.
  always_comb begin
    logic [CW:0] cand;
    logic        hit;
    win       = last_winner;
    win_found = 1'b0;
    cand      = '0;
    hit       = 1'b0;
    for (int i = 1; i <= NUM_COL; i++) begin
      cand = {1'b0, last_winner} + (CW+1)'(i);
      if (cand >= (CW+1)'(NUM_COL))
        cand = cand - (CW+1)'(NUM_COL);
      hit = 1'b0;
      for (int j = 0; j < NUM_COL; j++)
        if (cand == (CW+1)'(j) && req[j])
          hit = 1'b1;
      if (!win_found && hit) begin
        win       = cand[CW-1:0];
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int j = 0; j < NUM_COL; j++)
      if (win == CW'(j))
        win_oh[j] = 1'b1;
  end

  always_comb begin
    row_oh   = '0;
    lock_cur = 1'b0;
    for (int r = 0; r < NUM_ROW; r++)
      if (rp == RW'(r)) begin
        row_oh[r] = 1'b1;
        lock_cur  = row_lock[r];
      end
  end

  assign wcnt_nxt = wcnt + WW'(1);
  assign last_row = (rp == RW'(NUM_ROW - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      rp          <= '0;
      wcnt        <= '0;
      last_winner <= CW'(NUM_COL - 1);
      cur_win     <= '0;
      flush_tag   <= '0;
      tag_out     <= '0;
      gnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= ARB;
            rp    <= '0;
            wcnt  <= '0;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        ARB: begin
          if (win_found) begin
            state     <= FLUSH;
            cur_win   <= win;
            gnt       <= win_oh;
            flush_tag <= row_oh;
            tag_out   <= TW'(win) + TW'(1);
          end
        end
        FLUSH: begin
          state       <= WAIT;
          last_winner <= cur_win;
          wcnt        <= '0;
          gnt         <= '0;
          flush_tag   <= '0;
          tag_out     <= '0;
        end
        WAIT: begin
          // A lock seen on the timeout cycle wins over the timeout.
          if (lock_cur || wcnt_nxt == WW'(TIMEOUT)) begin
            if (!lock_cur)
              err <= 1'b1;
            wcnt <= '0;
            if (last_row) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ARB;
              rp    <= rp + RW'(1);
            end
          end else begin
            wcnt <= wcnt_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          rp    <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tag_flush_sched.sv
// Bench for tag_flush_sched with default parameters (4 columns, 4 rows,
// timeout 15). A per-cycle vector table covers the single-requester and
// round-robin passes; hand sequences cover timeout, lock/timeout tie,
// no-request hold and reset mid-pass.
module tb_tag_flush_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] row_lock = '0;
  logic [3:0] flush_tag;
  logic [2:0] tag_out;
  logic [3:0] gnt;
  logic       busy;
  logic       done;
  logic       err;

  tag_flush_sched #(.NUM_COL(4), .NUM_ROW(4), .TIMEOUT(15)) dut (
    .clk(clk), .rstn(rstn), .start(start), .req(req), .row_lock(row_lock),
    .flush_tag(flush_tag), .tag_out(tag_out), .gnt(gnt),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         st;
    logic [3:0] rq;
    logic [3:0] lk;
    logic [3:0] fl;
    logic [2:0] tg;
    logic [3:0] gn;
    bit         by;
    bit         dn;
    bit         er;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    start = 1'b0;
    #3;
    rstn  = 1'b1;
  endtask

  task automatic add(bit rst, bit st, logic [3:0] rq, logic [3:0] lk,
                     logic [3:0] fl, logic [2:0] tg, logic [3:0] gn,
                     bit by, bit dn, bit er);
    vec_t v;
    v.rst = rst; v.st = st; v.rq = rq; v.lk = lk;
    v.fl = fl; v.tg = tg; v.gn = gn; v.by = by; v.dn = dn; v.er = er;
    vq.push_back(v);
  endtask

  // One full pass with every row locking on its first WAIT cycle.
  // rr=0: single requester column 2; rr=1: all columns, rotating grants.
  task automatic build_pass(logic [3:0] rq, bit rr);
    logic [3:0] oh;
    add(1, 1, rq, 4'hf, 4'h0, 3'd0, 4'h0, 1, 0, 0);
    for (int r = 0; r < 4; r++) begin
      oh = 4'(1 << r);
      add(0, 0, rq, 4'hf, oh, rr ? 3'(r + 1) : 3'd3, rr ? oh : 4'b0100, 1, 0, 0);
      // start raised mid-pass must be ignored
      add(0, r == 1, rq, 4'hf, 4'h0, 3'd0, 4'h0, 1, 0, 0);
      if (r < 3)
        add(0, 0, rq, 4'hf, 4'h0, 3'd0, 4'h0, 1, 0, 0);
      else
        add(0, 0, rq, 4'hf, 4'h0, 3'd0, 4'h0, 0, 1, 0);
    end
    add(0, 0, rq, 4'hf, 4'h0, 3'd0, 4'h0, 0, 0, 0);
  endtask

  task automatic wait_done(string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      if (done) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #3;
    check("reset_outputs", {flush_tag, tag_out, gnt, busy, done, err}, 32'd0);
    rstn = 1'b1;

    build_pass(4'b0100, 0);
    build_pass(4'b1111, 1);
    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      start    = vq[i].st;
      req      = vq[i].rq;
      row_lock = vq[i].lk;
      tick();
      check($sformatf("vec%0d", i),
            {flush_tag, tag_out, gnt, busy, done, err},
            {vq[i].fl, vq[i].tg, vq[i].gn, vq[i].by, vq[i].dn, vq[i].er});
    end
    start = 1'b0;

    // Row 1 never locks: timeout after 15 WAIT cycles.
    do_reset();
    req = 4'b0001; row_lock = 4'b1101; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    tick();
    check("to_row1_flush", {flush_tag, tag_out, gnt}, {4'b0010, 3'd1, 4'b0001});
    repeat (15) tick();
    check("to_err_early", {busy, err}, {1'b1, 1'b0});
    tick();
    check("to_err_set", {busy, err, flush_tag}, {1'b1, 1'b1, 4'b0000});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("to_row2_flush", {flush_tag, err}, {4'b0100, 1'b1});
    wait_done("to_done_seen");
    check("to_err_at_done", 32'(err), 32'd1);
    tick();
    check("to_err_idle", {busy, err}, {1'b0, 1'b1});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("to_err_clear_start", {busy, err}, {1'b1, 1'b0});

    // Lock arrives on the 15th WAIT cycle of row 0: no error.
    do_reset();
    req = 4'b0001; row_lock = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    check("tie_still_wait", {busy, err, flush_tag}, {1'b1, 1'b0, 4'b0000});
    row_lock = 4'b0001;
    tick();
    check("tie_no_err", {busy, err}, {1'b1, 1'b0});
    tick();
    check("tie_advance", flush_tag, 4'b0010);
    row_lock = 4'b1111;
    wait_done("tie_done_seen");
    check("tie_err_at_done", 32'(err), 32'd0);

    // No request: pass parks in ARB until a column asks.
    do_reset();
    req = 4'b0000; row_lock = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("noreq_hold%0d", k), {busy, flush_tag, gnt, tag_out},
            {1'b1, 4'b0000, 4'b0000, 3'd0});
    end
    req = 4'b0001;
    tick();
    check("noreq_resume", {flush_tag, gnt, tag_out}, {4'b0001, 4'b0001, 3'd1});

    // Reset in WAIT: immediate clear, no done, restart favours column 0.
    row_lock = 4'b0000;
    tick();
    tick();
    check("rw_busy_before", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("rw_async_clear", {flush_tag, tag_out, gnt, busy, done, err}, 32'd0);
    #2;
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rw_idle%0d", k), {busy, done}, {1'b0, 1'b0});
    end
    req = 4'b1111; row_lock = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rw_restart", {flush_tag, gnt, tag_out}, {4'b0001, 4'b0001, 3'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
